// File: rtl/fx_pkg.sv
// Shared types and constants for the SPU simple-fixed-point pipe.
// Holds the op encoding, element sizes, saturation limits and stage record.
package fx_pkg;

  typedef enum logic [3:0] {
    FX_NOP  = 4'd0,
    FX_ADD  = 4'd1,
    FX_ADDS = 4'd2,
    FX_SUB  = 4'd3,
    FX_AND  = 4'd4,
    FX_OR   = 4'd5,
    FX_XOR  = 4'd6,
    FX_NAND = 4'd7,
    FX_CEQ  = 4'd8,
    FX_CGT  = 4'd9,
    FX_CLGT = 4'd10
  } fx_op_e;

  localparam logic [1:0] ESZ_B = 2'd0;
  localparam logic [1:0] ESZ_H = 2'd1;
  localparam logic [1:0] ESZ_W = 2'd2;

  localparam logic [31:0] SAT_MAX_B = 32'h0000_007F;
  localparam logic [31:0] SAT_MIN_B = 32'h0000_0080;
  localparam logic [31:0] SAT_MAX_H = 32'h0000_7FFF;
  localparam logic [31:0] SAT_MIN_H = 32'h0000_8000;
  localparam logic [31:0] SAT_MAX_W = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN_W = 32'h8000_0000;

  localparam int FX_DW = 128;
  localparam int FX_AW = 7;

  typedef struct packed {
    logic [FX_DW-1:0] value;
    logic [FX_AW-1:0] addr;
    logic             vld;
  } fx_stage_t;

  function automatic logic fx_op_writes(fx_op_e op);
    return (op != FX_NOP) && (op <= FX_CLGT);
  endfunction

  function automatic logic [31:0] fx_sat(logic neg, int w);
    logic [31:0] r;
    case (w)
      8:       r = neg ? SAT_MIN_B : SAT_MAX_B;
      16:      r = neg ? SAT_MIN_H : SAT_MAX_H;
      default: r = neg ? SAT_MIN_W : SAT_MAX_W;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fx_simd_alu.sv
// Combinational SIMD fixed-point ALU: byte, half and word lanes
// are all evaluated and the element size picks one.
import fx_pkg::*;

module fx_simd_alu #(
  parameter int DW = 128
) (
  input  logic [DW-1:0] ra,
  input  logic [DW-1:0] rb_eff,
  input  fx_op_e        op,
  input  logic [1:0]    esz,
  output logic [DW-1:0] result
);

  // Elements arrive zero-extended; w selects the live width.
  function automatic logic [31:0] elem_op(
    fx_op_e f_op, logic [31:0] a, logic [31:0] b, int w
  );
    logic [31:0] m, hb, s, xa, xb, r;
    logic sa, sb, ss;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    hb = m & ~(m >> 1);
    s  = (a + b) & m;
    sa = |(a & hb);
    sb = |(b & hb);
    ss = |(s & hb);
    xa = sa ? (a | ~m) : a;
    xb = sb ? (b | ~m) : b;
    case (f_op)
      FX_ADD:  r = s;
      FX_ADDS: r = (sa == sb && ss != sa) ? fx_sat(sa, w) : s;
      FX_SUB:  r = b - a;
      FX_AND:  r = a & b;
      FX_OR:   r = a | b;
      FX_XOR:  r = a ^ b;
      FX_NAND: r = ~(a & b);
      FX_CEQ:  r = (a == b) ? m : 32'd0;
      FX_CGT:  r = ($signed(xa) > $signed(xb)) ? m : 32'd0;
      FX_CLGT: r = (a > b) ? m : 32'd0;
      default: r = 32'd0;
    endcase
    return r & m;
  endfunction

  logic [DW-1:0] w_b;
  logic [DW-1:0] w_h;
  logic [DW-1:0] w_w;
  logic [31:0]   w_t;

  always_comb begin
    w_b = '0;
    w_h = '0;
    w_w = '0;
    w_t = '0;
    for (int i = 0; i < DW/8; i++) begin
      w_t = elem_op(op, {24'd0, ra[i*8 +: 8]},
                    {24'd0, rb_eff[i*8 +: 8]}, 8);
      w_b[i*8 +: 8] = w_t[7:0];
    end
    for (int i = 0; i < DW/16; i++) begin
      w_t = elem_op(op, {16'd0, ra[i*16 +: 16]},
                    {16'd0, rb_eff[i*16 +: 16]}, 16);
      w_h[i*16 +: 16] = w_t[15:0];
    end
    for (int i = 0; i < DW/32; i++) begin
      w_t = elem_op(op, ra[i*32 +: 32],
                    rb_eff[i*32 +: 32], 32);
      w_w[i*32 +: 32] = w_t;
    end
  end

  always_comb begin
    case (esz)
      ESZ_B:   result = w_b;
      ESZ_H:   result = w_h;
      default: result = w_w;
    endcase
  end

endmodule

// File: rtl/simple_fixed_pipe.sv
// SPU even-pipe simple-fixed-point unit: immediate mux, SIMD ALU
// and a LAT-deep stall/flush staging pipe with forwarding taps.
import fx_pkg::*;

module simple_fixed_pipe #(
  parameter int LAT = 2,
  parameter int DW  = FX_DW,
  parameter int AW  = FX_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  fx_op_e            op,
  input  logic [1:0]        esz,
  input  logic              use_imm,
  input  logic [9:0]        imm10,
  input  logic [DW-1:0]     ra,
  input  logic [DW-1:0]     rb,
  input  logic [AW-1:0]     rt_addr,
  input  logic              reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic [LAT*DW-1:0] fwd_val,
  output logic [LAT*AW-1:0] fwd_addr,
  output logic [LAT-1:0]    fwd_vld,
  output logic [DW-1:0]     rt_wb,
  output logic [AW-1:0]     rt_addr_wb,
  output logic              reg_write_wb
);

  logic [15:0]   w_imm16;
  logic [DW-1:0] w_rb_eff;
  logic [DW-1:0] w_res;
  fx_stage_t     w_in;
  fx_stage_t     r_stg [LAT];

  assign w_imm16 = {{6{imm10[9]}}, imm10};

  // Word lanes keep sign-extending past 16 bits.
  always_comb begin
    w_rb_eff = rb;
    if (use_imm) begin
      case (esz)
        ESZ_B:   w_rb_eff = {(DW/8){w_imm16[7:0]}};
        ESZ_H:   w_rb_eff = {(DW/16){w_imm16}};
        default: w_rb_eff = {(DW/32){{16{w_imm16[15]}}, w_imm16}};
      endcase
    end
  end

  fx_simd_alu #(.DW(DW)) u_alu (
    .ra     (ra),
    .rb_eff (w_rb_eff),
    .op     (op),
    .esz    (esz),
    .result (w_res)
  );

  always_comb begin
    w_in.value = FX_DW'(w_res);
    w_in.addr  = FX_AW'(rt_addr);
    w_in.vld   = issue_valid & reg_write & fx_op_writes(op);
  end

  // Flush only drops valid bits; values and addresses go stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) r_stg[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < LAT; k++) r_stg[k].vld <= 1'b0;
    end else if (!stall) begin
      r_stg[0] <= w_in;
      for (int k = 1; k < LAT; k++) r_stg[k] <= r_stg[k-1];
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_fwd
    assign fwd_val[k*DW +: DW]  = r_stg[k].value[DW-1:0];
    assign fwd_addr[k*AW +: AW] = r_stg[k].addr[AW-1:0];
    assign fwd_vld[k]           = r_stg[k].vld;
  end

  assign rt_wb        = r_stg[LAT-1].value[DW-1:0];
  assign rt_addr_wb   = r_stg[LAT-1].addr[AW-1:0];
  assign reg_write_wb = r_stg[LAT-1].vld;

endmodule

// File: tb/tb_simple_fixed_pipe.sv
// Directed bench for simple_fixed_pipe at LAT = 1, 2 and 8:
// ALU vector table plus latency, stall, flush and reset sequences.
import fx_pkg::*;

module tb_simple_fixed_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         issue_valid;
  fx_op_e       op;
  logic [1:0]   esz;
  logic         use_imm;
  logic [9:0]   imm10;
  logic [127:0] ra;
  logic [127:0] rb;
  logic [6:0]   rt_addr;
  logic         reg_write;
  logic         stall;
  logic         flush;

  logic [127:0]  a_fv;
  logic [6:0]    a_fa;
  logic [0:0]    a_fvl;
  logic [127:0]  a_wb;
  logic [6:0]    a_aw;
  logic          a_rw;

  logic [255:0]  b_fv;
  logic [13:0]   b_fa;
  logic [1:0]    b_fvl;
  logic [127:0]  b_wb;
  logic [6:0]    b_aw;
  logic          b_rw;

  logic [1023:0] c_fv;
  logic [55:0]   c_fa;
  logic [7:0]    c_fvl;
  logic [127:0]  c_wb;
  logic [6:0]    c_aw;
  logic          c_rw;

  simple_fixed_pipe #(.LAT(1)) u1 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .op(op), .esz(esz), .use_imm(use_imm), .imm10(imm10),
    .ra(ra), .rb(rb), .rt_addr(rt_addr),
    .reg_write(reg_write), .stall(stall), .flush(flush),
    .fwd_val(a_fv), .fwd_addr(a_fa), .fwd_vld(a_fvl),
    .rt_wb(a_wb), .rt_addr_wb(a_aw), .reg_write_wb(a_rw)
  );

  simple_fixed_pipe #(.LAT(2)) u2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .op(op), .esz(esz), .use_imm(use_imm), .imm10(imm10),
    .ra(ra), .rb(rb), .rt_addr(rt_addr),
    .reg_write(reg_write), .stall(stall), .flush(flush),
    .fwd_val(b_fv), .fwd_addr(b_fa), .fwd_vld(b_fvl),
    .rt_wb(b_wb), .rt_addr_wb(b_aw), .reg_write_wb(b_rw)
  );

  simple_fixed_pipe #(.LAT(8)) u8 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .op(op), .esz(esz), .use_imm(use_imm), .imm10(imm10),
    .ra(ra), .rb(rb), .rt_addr(rt_addr),
    .reg_write(reg_write), .stall(stall), .flush(flush),
    .fwd_val(c_fv), .fwd_addr(c_fa), .fwd_vld(c_fvl),
    .rt_wb(c_wb), .rt_addr_wb(c_aw), .reg_write_wb(c_rw)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    fx_op_e       op;
    logic [1:0]   esz;
    logic         imm;
    logic [9:0]   imm10;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] exp;
    logic         wr;
  } vec_t;

  vec_t vq[$];
  int   nchk = 0;
  int   nerr = 0;

  function automatic logic [127:0] r32(logic [31:0] x);
    return {4{x}};
  endfunction
  function automatic logic [127:0] r16(logic [15:0] x);
    return {8{x}};
  endfunction
  function automatic logic [127:0] r8(logic [7:0] x);
    return {16{x}};
  endfunction

  task automatic chk(string nm, logic [1023:0] act,
                     logic [1023:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(string nm, fx_op_e o, logic [1:0] e,
                     logic im, logic [9:0] iv, logic [127:0] a,
                     logic [127:0] b, logic [127:0] x, logic w);
    vec_t v;
    v.name = nm; v.op = o; v.esz = e; v.imm = im;
    v.imm10 = iv; v.ra = a; v.rb = b; v.exp = x; v.wr = w;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(int k);
    issue_valid = 1'b1;
    op = FX_ADD;
    esz = ESZ_W;
    use_imm = 1'b0;
    ra = r32(32'(k));
    rb = '0;
    rt_addr = 7'(k);
    reg_write = 1'b1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_u1_fv"}, 1024'(a_fv), '0);
    chk({tag, "_u1_fa"}, 1024'(a_fa), '0);
    chk({tag, "_u1_fvl"}, 1024'(a_fvl), '0);
    chk({tag, "_u1_wb"}, 1024'(a_wb), '0);
    chk({tag, "_u1_aw"}, 1024'(a_aw), '0);
    chk({tag, "_u1_rw"}, 1024'(a_rw), '0);
    chk({tag, "_u2_fv"}, 1024'(b_fv), '0);
    chk({tag, "_u2_fa"}, 1024'(b_fa), '0);
    chk({tag, "_u2_fvl"}, 1024'(b_fvl), '0);
    chk({tag, "_u2_wb"}, 1024'(b_wb), '0);
    chk({tag, "_u2_aw"}, 1024'(b_aw), '0);
    chk({tag, "_u2_rw"}, 1024'(b_rw), '0);
    chk({tag, "_u8_fv"}, c_fv, '0);
    chk({tag, "_u8_fa"}, 1024'(c_fa), '0);
    chk({tag, "_u8_fvl"}, 1024'(c_fvl), '0);
    chk({tag, "_u8_wb"}, 1024'(c_wb), '0);
    chk({tag, "_u8_aw"}, 1024'(c_aw), '0);
    chk({tag, "_u8_rw"}, 1024'(c_rw), '0);
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; issue_valid = 1'b0; op = FX_NOP;
    esz = ESZ_W; use_imm = 1'b0; imm10 = '0;
    ra = '0; rb = '0; rt_addr = '0; reg_write = 1'b1;
    stall = 1'b0; flush = 1'b0;

    add("add_w", FX_ADD, 2'd2, 0, 0, r32(1), r32(2), r32(3), 1);
    add("adds_hmax", FX_ADDS, 2'd1, 0, 0, r16(16'h7FFF),
        r16(16'h0001), r16(16'h7FFF), 1);
    add("adds_hmin", FX_ADDS, 2'd1, 0, 0, r16(16'h8000),
        r16(16'hFFFF), r16(16'h8000), 1);
    add("adds_hok", FX_ADDS, 2'd1, 0, 0, r16(16'h0005),
        r16(16'hFFFE), r16(16'h0003), 1);
    add("cgt_b", FX_CGT, 2'd0, 0, 0, r8(8'h80), r8(8'h01),
        r8(8'h00), 1);
    add("clgt_b", FX_CLGT, 2'd0, 0, 0, r8(8'h80), r8(8'h01),
        r8(8'hFF), 1);
    add("sub_imm_w", FX_SUB, 2'd2, 1, 10'h3FF, '0, r32(5),
        r32(32'hFFFF_FFFF), 1);
    add("add_b_wrap", FX_ADD, 2'd0, 0, 0, r8(8'hFF), r8(8'h02),
        r8(8'h01), 1);
    add("sub_h", FX_SUB, 2'd1, 0, 0, r16(16'h0003),
        r16(16'h0001), r16(16'hFFFE), 1);
    add("adds_bneg", FX_ADDS, 2'd0, 0, 0, r8(8'h80), r8(8'h80),
        r8(8'h80), 1);
    add("adds_wmax", FX_ADDS, 2'd2, 0, 0, r32(32'h7FFF_FFFF),
        r32(1), r32(32'h7FFF_FFFF), 1);
    add("xor", FX_XOR, 2'd0, 0, 0, r32(32'hF0F0_F0F0),
        r32(32'hFF00_FF00), r32(32'h0FF0_0FF0), 1);
    add("nand", FX_NAND, 2'd1, 0, 0, r32(32'hFFFF_0000),
        r32(32'hFF00_FF00), r32(32'h00FF_FFFF), 1);
    add("or", FX_OR, 2'd2, 0, 0, r32(32'h0F0F_0000),
        r32(32'h00F0_000F), r32(32'h0FFF_000F), 1);
    add("and", FX_AND, 2'd2, 0, 0, r32(32'h0F0F_00FF),
        r32(32'h00FF_0F0F), r32(32'h000F_000F), 1);
    add("ceq_h", FX_CEQ, 2'd1, 0, 0, r16(16'h1234),
        r16(16'h1234), r16(16'hFFFF), 1);
    add("esz3_word", FX_ADD, 2'd3, 0, 0, r32(32'h0000_FFFF),
        r32(1), r32(32'h0001_0000), 1);
    add("imm_b", FX_ADD, 2'd0, 1, 10'h081, r8(8'h01), '0,
        r8(8'h82), 1);
    add("imm_h", FX_ADD, 2'd1, 1, 10'h200, r16(16'h0100), '0,
        r16(16'hFF00), 1);
    add("cgt_w", FX_CGT, 2'd2, 0, 0, r32(32'hFFFF_FFFF), r32(1),
        '0, 1);
    add("clgt_w", FX_CLGT, 2'd2, 0, 0, r32(32'hFFFF_FFFF),
        r32(1), r32(32'hFFFF_FFFF), 1);
    add("nop", FX_NOP, 2'd2, 0, 0, r32(7), r32(9), '0, 0);
    add("bad_op", fx_op_e'(4'd13), 2'd2, 0, 0, r32(7), r32(9),
        '0, 0);

    tick();
    tick();
    reset = 1'b0;
    chk_zero("reset");

    foreach (vq[i]) begin
      issue_valid = 1'b1;
      op = vq[i].op; esz = vq[i].esz;
      use_imm = vq[i].imm; imm10 = vq[i].imm10;
      ra = vq[i].ra; rb = vq[i].rb;
      rt_addr = 7'(i + 1); reg_write = 1'b1;
      tick();
      chk(vq[i].name, 1024'(a_wb), 1024'(vq[i].exp));
      chk({vq[i].name, "_wr"}, 1024'(a_rw), 1024'(vq[i].wr));
      if (vq[i].wr)
        chk({vq[i].name, "_addr"}, 1024'(a_aw), 1024'(i + 1));
    end
    issue_valid = 1'b0;

    rst_pulse();
    iss(3);
    ra = r32(1); rb = r32(2);
    tick();
    issue_valid = 1'b0;
    chk("lat_early_rw", 1024'(b_rw), 0);
    chk("lat_early_wb", 1024'(b_wb), 0);
    chk("lat_early_fvl", 1024'(b_fvl), 1024'(2'b01));
    tick();
    chk("lat_wb", 1024'(b_wb), 1024'(r32(3)));
    chk("lat_rw", 1024'(b_rw), 1);
    chk("lat_addr", 1024'(b_aw), 3);
    tick();
    chk("lat_after_rw", 1024'(b_rw), 0);

    rst_pulse();
    n = 0;
    for (int s = 1; s <= 10; s++) begin
      issue_valid = 1'b0;
      stall = 1'b0;
      case (s)
        1: iss(1);
        2: iss(2);
        3, 4, 5: begin iss(3); stall = 1'b1; end
        6: iss(3);
        7: iss(4);
        default: ;
      endcase
      #1;
      if (b_rw && !stall) begin
        chk("stall_addr", 1024'(b_aw), 1024'(n + 1));
        chk("stall_val", 1024'(b_wb), 1024'(r32(32'(n + 1))));
        chk("stall_step", 1024'(s), 1024'(n + 6));
        n++;
      end
      if (s == 4) begin
        chk("stall_fvl", 1024'(b_fvl), 1024'(2'b11));
        chk("stall_fa", 1024'(b_fa), 1024'({7'd1, 7'd2}));
      end
      if (s == 7) begin
        chk("resume_fvl", 1024'(b_fvl), 1024'(2'b11));
        chk("resume_fa", 1024'(b_fa), 1024'({7'd2, 7'd3}));
      end
      tick();
    end
    chk("stall_count", 1024'(n), 4);

    rst_pulse();
    iss(5); tick();
    iss(6); tick();
    iss(7); flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_u8_fvl", 1024'(c_fvl), 0);
    chk("flush_u2_fvl", 1024'(b_fvl), 0);
    chk("flush_u8_rw", 1024'(c_rw), 0);
    iss(8); tick();
    issue_valid = 1'b0;
    chk("postflush_fvl", 1024'(c_fvl), 1024'(8'h01));
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("postflush_rw%0d", i), 1024'(c_rw),
          1024'(i == 7));
      if (i == 7) begin
        chk("postflush_addr", 1024'(c_aw), 8);
        chk("postflush_val", 1024'(c_wb), 1024'(r32(8)));
      end
    end

    rst_pulse();
    for (int k = 1; k <= 8; k++) begin
      iss(k);
      tick();
    end
    stall = 1'b1;
    tick();
    tick();
    chk("full_fvl", 1024'(c_fvl), 1024'(8'hFF));
    chk("full_wb", 1024'(c_wb), 1024'(r32(1)));
    reset = 1'b1;
    tick();
    chk_zero("rst_full");
    reset = 1'b0;
    stall = 1'b0;
    issue_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/simple_fixed_pipe.md
# simple_fixed_pipe

Parametrised simple-fixed-point execution pipe for the SPU even pipeline. It computes one 128-bit SIMD fixed-point result per issue cycle and carries it through a configurable number of staging stages to writeback. Unlike the earlier fixed-latency unit, it adds stall, flush, per-element width selection, saturating add and an immediate-operand path. It also exposes every in-flight stage on a forwarding bus for the RF/FWD stage.

## Interface
- LAT, 2: issue-to-writeback latency in cycles; legal range 1..8.
- DW, 128: register width; must be a multiple of 32.
- AW, 7: destination register address width.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- issue_valid  in  1  instruction presented this cycle.
- op  in  fx_op_e  decoded operation (from package).
- esz  in  2  element size: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- use_imm  in  1  replace rb with the replicated immediate.
- imm10  in  10  signed immediate.
- ra, rb  in  DW  source operand values.
- rt_addr  in  AW  destination address.
- reg_write  in  1  instruction writes the register file.
- stall  in  1  freeze the whole pipe.
- flush  in  1  kill every in-flight instruction.
- fwd_val  out  LAT×DW  result value at stage k (k = 0 is youngest).
- fwd_addr  out  LAT×AW  destination address at stage k.
- fwd_vld  out  LAT  stage k holds a valid instruction with reg_write set.
- rt_wb  out  DW  writeback value.
- rt_addr_wb  out  AW  writeback address.
- reg_write_wb  out  1  writeback strobe.

## Operation
- Operations (fx_op_e):
  - FX_NOP.
  - FX_ADD: modulo add per element.
  - FX_ADDS: signed saturating add; clamps to 0x7F / 0x7FFF / 0x7FFFFFFF or 0x80 / 0x8000 / 0x80000000.
  - FX_SUB: rt = rb − ra per element, modulo.
  - FX_AND, FX_OR, FX_XOR, FX_NAND: bitwise, esz ignored.
  - FX_CEQ, FX_CGT (signed), FX_CLGT (unsigned): an element is all-ones when the relation holds, else zero.
- Immediate path: with use_imm = 1, each element of rb is replaced by imm10 sign-extended to 16 bits, then truncated to the element width (byte uses the low 8 bits).
- Element numbering: element i occupies bits [i*W +: W], where W is the element width.
- Stage 0 is loaded with {result, rt_addr, issue_valid & reg_write & op != FX_NOP}.
- Stage k loads from stage k−1; stage LAT−1 drives the wb outputs.
- An unknown op enum value behaves as FX_NOP: zero value, no write.
- fwd_vld[k] is the stage valid bit; fwd_val and fwd_addr are meaningful only when fwd_vld[k] is set.

## Timing
- Reset (synchronous): every stage value, address and valid bit clears to 0, so rt_wb = 0, rt_addr_wb = 0, reg_write_wb = 0, fwd_* = 0 on the cycle after reset.
  - Reset mid-operation discards all in-flight work.
- Latency: an instruction issued at edge N appears on the wb outputs after edge N+LAT when no stalls occur. Each stall cycle adds one cycle.
- Throughput: one instruction per cycle.
- stall = 1: all stages hold; issue inputs are ignored (the upstream stage must re-present the instruction); wb outputs hold their values, and reg_write_wb stays asserted if it was set. The consumer accepts writeback only when stall = 0.
- flush = 1: all valid bits clear at the next edge. Value and address registers may keep stale data. The instruction presented in the same cycle is also dropped.
- flush and stall together: flush wins.
- LAT = 1: the stage-0 register is the wb register; fwd has a single entry.
- Saturation detection uses the operand sign bits and the result sign bit; adding two negatives that produce a positive result clamps to the minimum.

## Structure
- Package fx_pkg holds:
  - the fx_op_e enum;
  - esz localparams;
  - per-width MAX/MIN saturation constants;
  - the fx_stage_t struct {value, addr, vld}.
- Sub-module fx_simd_alu: purely combinational, taking ra, rb_eff, op and esz and producing the result. It is instantiated once. The top level holds the immediate mux and the stage shift register as an array of fx_stage_t with stall/flush control.

## Test plan
- Reset, then ADD with esz = 2, ra = 0x00000001×4, rb = 0x00000002×4, LAT = 2 -> rt_wb = 0x00000003×4 with reg_write_wb = 1 exactly 2 cycles after issue. Before that, all outputs are 0.
- ADDS with esz = 1: ra half = 0x7FFF, rb half = 0x0001 -> 0x7FFF. ra = 0x8000, rb = 0xFFFF -> 0x8000. ra = 0x0005, rb = 0xFFFE -> 0x0003.
- CGT byte, ra byte = 0x80, rb byte = 0x01 -> 0x00. CLGT on the same operands -> 0xFF. With use_imm = 1 and imm10 = 0x3FF, SUB word with ra = 0 gives 0xFFFFFFFF.
- Back-to-back issue of 4 ops, with stall held for 3 cycles mid-stream -> results are in order, none lost or duplicated, and each is delayed exactly 3 cycles. fwd_vld/fwd_addr track every stage.
- flush asserted while 2 ops are in flight and a third is issued in the same cycle -> none reach writeback and reg_write_wb stays 0. An op issued the cycle after the flush completes normally.
- Reset asserted while the pipe is full and stalled -> all outputs are 0 after the next edge. Repeat with LAT = 1 and LAT = 8.
